song_sequencer: RTL and testbench

Playback controller for the song library block. It selects a song, snapshots the library's 56-slot note word and duration word, then steps through the slots one at a time. Each note is held for its programmed number of time units, with support for pause, stop and end-of-song detection. Its note output drives the buzzer/tone generator; its `song_num` output drives the library's song-select input.

---
 rtl/song_sequencer.sv | 162 ++++++++++++++++
 tb/tb_song_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Playback controller: snapshots a song's note/duration slots from the library,
// then steps through them, holding each note for its duration in TICK_DIV units.
module song_sequencer #(
  parameter int TICK_DIV = 25_000_000,
  parameter int SLOTS    = 56
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic [1:0]         song_sel,
  input  logic [4*SLOTS-1:0] song_packed,
  input  logic [4*SLOTS-1:0] time_continue,
  output logic [1:0]         song_num,
  output logic [3:0]         note,
  output logic               note_valid,
  output logic [5:0]         note_idx,
  output logic               busy,
  output logic               done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [5:0]    LAST_IDX = 6'(SLOTS);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_PLAY, S_PAUSED, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    song_num_q, song_num_d;
  logic [3:0]    note_q, note_d;
  logic          nv_q, nv_d;
  logic [5:0]    idx_q, idx_d;
  logic [3:0]    dur_q, dur_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    notes_q [SLOTS];
  logic [3:0]    notes_d [SLOTS];
  logic [3:0]    durs_q  [SLOTS];
  logic [3:0]    durs_d  [SLOTS];
  logic          load;
  logic [SW-1:0] slot;
  logic [3:0]    cur_note, cur_dur;
  logic          wrap;

  assign slot     = idx_q[SW-1:0];
  assign cur_note = notes_q[slot];
  assign cur_dur  = durs_q[slot];
  assign wrap     = (tick_q == TICK_MAX);

  always_comb begin
    state_d    = state_q;
    song_num_d = song_num_q;
    note_d     = note_q;
    nv_d       = nv_q;
    idx_d      = idx_q;
    dur_d      = dur_q;
    tick_d     = tick_q;
    load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          song_num_d = (song_sel == 2'b11) ? 2'b00 : song_sel;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        idx_d   = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        nv_d = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else if (cur_note == 4'hF) begin
          idx_d = idx_q + 6'd1;
        end else begin
          note_d  = cur_note;
          nv_d    = 1'b1;
          dur_d   = (cur_dur == 4'd0) ? 4'd1 : cur_dur;
          tick_d  = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // The cycle in which pause is sampled still counts as sounding time,
        // so a paused note keeps its full d*TICK_DIV high cycles.
        tick_d = wrap ? '0 : tick_q + TW'(1);
        if (wrap && dur_q <= 4'd1) begin
          nv_d    = 1'b0;
          idx_d   = idx_q + 6'd1;
          state_d = S_FETCH;
        end else begin
          if (wrap) dur_d = dur_q - 4'd1;
          if (pause) begin
            nv_d    = 1'b0;
            state_d = S_PAUSED;
          end
        end
      end
      S_PAUSED: begin
        if (!pause) begin
          nv_d    = 1'b1;
          state_d = S_PLAY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      nv_d    = 1'b0;
      idx_d   = '0;
    end

    for (int k = 0; k < SLOTS; k++) begin
      notes_d[k] = load ? song_packed[4*(SLOTS-1-k) +: 4]   : notes_q[k];
      durs_d[k]  = load ? time_continue[4*(SLOTS-1-k) +: 4] : durs_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      song_num_q <= '0;
      note_q     <= '0;
      nv_q       <= 1'b0;
      idx_q      <= '0;
      dur_q      <= '0;
      tick_q     <= '0;
      for (int k = 0; k < SLOTS; k++) begin
        notes_q[k] <= '0;
        durs_q[k]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      song_num_q <= song_num_d;
      note_q     <= note_d;
      nv_q       <= nv_d;
      idx_q      <= idx_d;
      dur_q      <= dur_d;
      tick_q     <= tick_d;
      for (int k = 0; k < SLOTS; k++) begin
        notes_q[k] <= notes_d[k];
        durs_q[k]  <= durs_d[k];
      end
    end
  end

  assign song_num   = song_num_q;
  assign note       = note_q;
  assign note_valid = nv_q;
  assign note_idx   = idx_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: per-cycle vector table on a short song, plus
// directed sequences for full playback, filler lead-in, stop, pause and reset.
module tb_song_sequencer;
  localparam int TD = 4;
  localparam int NS = 56;

  logic          clk = 1'b0;
  logic          rst, start, pause, stop;
  logic [1:0]    song_sel;
  logic [4*NS-1:0] song_packed, time_continue;
  logic [1:0]    song_num;
  logic [3:0]    note;
  logic          note_valid;
  logic [5:0]    note_idx;
  logic          busy, done;

  song_sequencer #(.TICK_DIV(TD), .SLOTS(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .song_sel(song_sel), .song_packed(song_packed), .time_continue(time_continue),
    .song_num(song_num), .note(note), .note_valid(note_valid),
    .note_idx(note_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Library model: song 0 plain, song 1 with six leading fillers,
  // song 2 = two short notes (first with duration 0) then all fillers.
  function automatic logic [4*NS-1:0] lib_notes(input logic [1:0] s);
    logic [4*NS-1:0] v;
    logic [3:0] n;
    v = '0;
    for (int k = 0; k < NS; k++) begin
      case (s)
        2'd0:    n = (k == 1) ? 4'd2 : (k == 3) ? 4'd3 : (k < 4) ? 4'd0 : 4'(k % 8);
        2'd1:    n = (k < 6) ? 4'hF : 4'((k % 7) + 1);
        2'd2:    n = (k == 0) ? 4'd5 : (k == 1) ? 4'd6 : 4'hF;
        default: n = 4'd0;
      endcase
      v[4*(NS-1-k) +: 4] = n;
    end
    return v;
  endfunction

  function automatic logic [4*NS-1:0] lib_durs(input logic [1:0] s);
    logic [4*NS-1:0] v;
    logic [3:0] d;
    v = '0;
    for (int k = 0; k < NS; k++) begin
      if (s == 2'd2) d = (k == 0) ? 4'd0 : (k == 1) ? 4'd1 : 4'd9;
      else           d = 4'd5;
      v[4*(NS-1-k) +: 4] = d;
    end
    return v;
  endfunction

  assign song_packed   = lib_notes(song_num);
  assign time_continue = lib_durs(song_num);

  typedef struct {
    logic       start;
    logic       pause;
    logic [1:0] sel;
    logic [3:0] note;
    logic       nv;
    logic [5:0] idx;
    logic       busy;
    logic       done;
    logic [1:0] snum;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_n[4] = '{0, 2, 0, 3};

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic add_row(input logic st, input logic pa, input logic [1:0] sel,
                         input logic [3:0] nt, input logic nv, input int idx,
                         input logic bz, input logic dn, input logic [1:0] sn);
    vec_t r;
    r.start = st; r.pause = pa; r.sel = sel; r.note = nt; r.nv = nv;
    r.idx = 6'(idx); r.busy = bz; r.done = dn; r.snum = sn;
    tbl.push_back(r);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " song_num"},   int'(song_num),   0);
    chk({tag, " note"},       int'(note),       0);
    chk({tag, " note_valid"}, int'(note_valid), 0);
    chk({tag, " note_idx"},   int'(note_idx),   0);
    chk({tag, " busy"},       int'(busy),       0);
    chk({tag, " done"},       int'(done),       0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, first, done_at, ndone, nr, nf, cnt, hi, lo;
    int rise[4], fall[4], rnote[4], ridx[4];
    logic pv;

    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; song_sel = 2'd0;
    step; step;
    chk_reset("reset");
    rst = 1'b0;

    // Song 2 cycle by cycle: dur-0 note (4 cycles), dur-1 note, fillers, done.
    add_row(1, 0, 2, 0, 0, 0, 1, 0, 2);  // LOAD
    add_row(0, 0, 0, 0, 0, 0, 1, 0, 2);  // FETCH; song_sel toggled after capture
    add_row(0, 0, 0, 5, 1, 0, 1, 0, 2);  // first note
    add_row(1, 0, 1, 5, 1, 0, 1, 0, 2);  // start while busy ignored
    add_row(0, 0, 1, 5, 1, 0, 1, 0, 2);
    add_row(0, 0, 1, 5, 1, 0, 1, 0, 2);
    add_row(0, 0, 0, 5, 0, 1, 1, 0, 2);  // gap
    for (int i = 0; i < 4; i++) add_row(0, 0, 0, 6, 1, 1, 1, 0, 2);
    add_row(0, 0, 0, 6, 0, 2, 1, 0, 2);
    for (int m = 1; m <= 54; m++) add_row(0, 0, 0, 6, 0, 2 + m, 1, 0, 2);
    add_row(0, 0, 0, 6, 0, 56, 1, 1, 2); // DONE
    add_row(1, 0, 0, 6, 0, 56, 0, 0, 2); // start during DONE does not restart
    add_row(0, 1, 0, 6, 0, 56, 0, 0, 2);

    foreach (tbl[i]) begin
      start = tbl[i].start; pause = tbl[i].pause; song_sel = tbl[i].sel;
      step;
      chk($sformatf("row%0d note", i),       int'(note),       int'(tbl[i].note));
      chk($sformatf("row%0d note_valid", i), int'(note_valid), int'(tbl[i].nv));
      chk($sformatf("row%0d note_idx", i),   int'(note_idx),   int'(tbl[i].idx));
      chk($sformatf("row%0d busy", i),       int'(busy),       int'(tbl[i].busy));
      chk($sformatf("row%0d done", i),       int'(done),       int'(tbl[i].done));
      chk($sformatf("row%0d song_num", i),   int'(song_num),   int'(tbl[i].snum));
    end
    start = 1'b0; pause = 1'b0;

    // Song 0 full playback.
    for (int i = 0; i < 4; i++) begin
      rise[i] = -1000; fall[i] = -1000; rnote[i] = -1; ridx[i] = -1;
    end
    song_sel = 2'd0; start = 1'b1; step; start = 1'b0;
    t = 1; pv = 1'b0; first = -1; done_at = -1; ndone = 0; nr = 0; nf = 0;
    while (t < 1400 && done_at < 0) begin
      step; t++;
      if (note_valid && !pv) begin
        if (first < 0) first = t;
        if (nr < 4) begin
          rise[nr] = t; rnote[nr] = int'(note); ridx[nr] = int'(note_idx); nr++;
        end
      end
      if (!note_valid && pv && nf < 4) begin
        fall[nf] = t; nf++;
      end
      if (done) begin
        done_at = t; ndone++;
        chk("s0 busy during done", int'(busy), 1);
      end
      pv = note_valid;
    end
    chk("s0 first note latency", first, 3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s0 note%0d value", i), rnote[i], exp_n[i]);
      chk($sformatf("s0 note%0d idx", i), ridx[i], i);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s0 note%0d high cycles", i), fall[i] - rise[i], 20);
      chk($sformatf("s0 gap after note%0d", i), rise[i+1] - fall[i], 1);
    end
    chk("s0 done seen", int'(done_at >= 0), 1);
    chk("s0 first note to done", done_at - rise[0], 1176);
    repeat (5) begin
      step;
      if (done) ndone++;
    end
    chk("s0 done pulse count", ndone, 1);
    chk("s0 busy after done", int'(busy), 0);

    // Song 1: six fillers delay the first note; then stop at index 30.
    song_sel = 2'd1; start = 1'b1; step; start = 1'b0;
    t = 1; pv = 1'b0; first = -1; ndone = 0;
    while (t < 40 && first < 0) begin
      step; t++;
      if (note_valid && !pv) first = t;
      pv = note_valid;
    end
    chk("s1 first note latency", first, 9);
    chk("s1 first note idx", int'(note_idx), 6);
    chk("s1 first note value", int'(note), 7);
    cnt = 0;
    while (cnt < 800 && !(note_idx == 6'd30 && note_valid)) begin
      step; cnt++;
      if (done) ndone++;
    end
    chk("s1 reached idx 30", int'(note_idx), 30);
    stop = 1'b1; step; stop = 1'b0;
    chk("stop busy", int'(busy), 0);
    chk("stop note_idx", int'(note_idx), 0);
    chk("stop note_valid", int'(note_valid), 0);
    repeat (40) begin
      if (done) ndone++;
      step;
    end
    chk("stop no done pulse", ndone, 0);

    // song_sel=11 maps to song 0; toggling song_sel mid-song; pause 10 cycles.
    song_sel = 2'b11; start = 1'b1; step; start = 1'b0;
    chk("sel11 song_num", int'(song_num), 0);
    song_sel = 2'd2;
    cnt = 0;
    while (cnt < 100 && !(note_idx == 6'd1 && note_valid)) begin step; cnt++; end
    chk("sel toggle idx1 note", int'(note), 2);
    cnt = 0;
    while (cnt < 200 && !(note_idx == 6'd3 && note_valid)) begin step; cnt++; end
    hi = 1; lo = 0;
    repeat (6) begin
      step;
      if (note_valid) hi++;
    end
    pause = 1'b1;
    repeat (10) begin
      step;
      if (!note_valid) lo++;
    end
    chk("pause note held", int'(note), 3);
    chk("pause busy", int'(busy), 1);
    pause = 1'b0;
    step; cnt = 0;
    while (note_valid && cnt < 100) begin hi++; step; cnt++; end
    chk("pause low cycles", lo, 10);
    chk("paused note high cycles", hi, 20);
    chk("after paused note idx", int'(note_idx), 4);
    stop = 1'b1; step; stop = 1'b0;

    // Reset while PAUSED.
    song_sel = 2'd1; start = 1'b1; step; start = 1'b0;
    cnt = 0;
    while (cnt < 40 && !note_valid) begin step; cnt++; end
    pause = 1'b1; step; step;
    chk("paused note_valid", int'(note_valid), 0);
    chk("paused note", int'(note), 7);
    rst = 1'b1; step; rst = 1'b0; pause = 1'b0;
    chk_reset("rst in paused");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
